// File: rtl/snake_dir_input.sv
// Button front end for the snake game: synchronises and debounces four raw
// push-buttons, detects presses, filters out 180-degree reversals and turns
// accepted presses into one-hot direction pulses. It also tracks the heading.
//
// state | meaning
// IDLE  | no pulse driven; an accepted press or a pending request starts one
// PULSE | one-hot output held for HOLD_CYCLES; newer accepted presses queue in pending
module snake_dir_input #(
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter int         HOLD_CYCLES     = 1,
  parameter logic [1:0] INIT_DIR        = 2'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       game_over,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [1:0] heading,
  output logic       busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_TC = HW'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, PULSE} state_t;

  // Bit index equals the direction code: 0=UP 1=DOWN 2=LEFT 3=RIGHT.
  logic [3:0]    raw;
  logic [3:0]    sync1, sync2;
  logic [3:0]    db, db_q, press;
  logic [CW-1:0] cnt [4];

  state_t        state;
  logic [3:0]    dir_out;
  logic [HW-1:0] hold_cnt;
  logic          pend_valid;
  logic [1:0]    pend_dir;

  logic          req_valid;
  logic [1:0]    req_dir;
  logic          accept;
  logic          issue;
  logic [1:0]    issue_dir;

  assign raw = {btn_right, btn_left, btn_down, btn_up};

  // Two-flop synchroniser per button.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: the level follows sync only after DEBOUNCE_CYCLES differing cycles in a row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_TC) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Registered press edges; presses seen while the game is over are discarded for good.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_q  <= '0;
      press <= '0;
    end else begin
      db_q  <= db;
      press <= db & ~db_q & {4{~game_over}};
    end
  end

  // Priority pick among simultaneous presses and reversal filtering against the heading.
  always_comb begin
    req_valid = |press;
    if (press[0])      req_dir = 2'd0;
    else if (press[1]) req_dir = 2'd1;
    else if (press[2]) req_dir = 2'd2;
    else               req_dir = 2'd3;
    // Same axis means either the current heading or its reversal.
    accept    = req_valid && !game_over && (req_dir[1] != heading[1]);
    issue     = accept || pend_valid;
    issue_dir = accept ? req_dir : pend_dir;
  end

  // Pulse sequencer with heading tracking and a one-deep pending slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      dir_out    <= '0;
      busy       <= 1'b0;
      heading    <= INIT_DIR;
      hold_cnt   <= '0;
      pend_valid <= 1'b0;
      pend_dir   <= '0;
    end else if (game_over) begin
      state      <= IDLE;
      dir_out    <= '0;
      busy       <= 1'b0;
      hold_cnt   <= '0;
      pend_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            state      <= PULSE;
            heading    <= issue_dir;
            dir_out    <= 4'b0001 << issue_dir;
            busy       <= 1'b1;
            hold_cnt   <= '0;
            pend_valid <= 1'b0;
          end
        end
        PULSE: begin
          if (accept) begin
            pend_valid <= 1'b1;
            pend_dir   <= req_dir;
          end
          if (hold_cnt == HOLD_TC) begin
            state   <= IDLE;
            dir_out <= '0;
            busy    <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign up    = dir_out[0];
  assign down  = dir_out[1];
  assign left  = dir_out[2];
  assign right = dir_out[3];

endmodule

// File: tb/tb_snake_dir_input.sv
// Bench for snake_dir_input: directed scenarios plus randomized button
// activity, all checked cycle by cycle against a behavioural model.
module tb_snake_dir_input;

  localparam int DC   = 4;
  localparam int HOLD = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic       game_over;
  logic       up, down, left, right, busy;
  logic [1:0] heading;
  logic [6:0] obs;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  snake_dir_input #(.DEBOUNCE_CYCLES(DC), .HOLD_CYCLES(HOLD), .INIT_DIR(2'd3)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]),
    .game_over(game_over),
    .up(up), .down(down), .left(left), .right(right),
    .heading(heading), .busy(busy)
  );

  always #10 clk = ~clk;

  assign obs = {busy, heading, right, left, down, up};

  // ---------------- reference model ----------------
  // Raw samples newest first; a debounced level flips once the DC samples
  // that reached the synchroniser output all disagree with it.
  logic [3:0] hist [DC+1];
  logic [3:0] mdb, mrose, mpress;
  int         mrem;
  logic [1:0] mcur, mhead, mpd;
  logic       mpv;

  function automatic void model_reset();
    for (int j = 0; j <= DC; j++) hist[j] = '0;
    mdb = '0; mrose = '0; mpress = '0;
    mrem = 0; mcur = '0; mhead = 2'd3; mpv = 1'b0; mpd = '0;
  endfunction

  function automatic logic [1:0] opposite(input logic [1:0] d);
    case (d)
      2'd0: return 2'd1;
      2'd1: return 2'd0;
      2'd2: return 2'd3;
      default: return 2'd2;
    endcase
  endfunction

  function automatic void model_edge(input logic [3:0] r, input logic g);
    int   req;
    logic acc;
    logic flip;
    req = -1;
    for (int b = 3; b >= 0; b--) if (mpress[b]) req = b;
    acc = (req >= 0) && !g && (2'(req) != mhead) && (2'(req) != opposite(mhead));
    if (g) begin
      mrem = 0; mpv = 1'b0;
    end else if (mrem > 0) begin
      if (acc) begin mpv = 1'b1; mpd = 2'(req); end
      mrem--;
    end else if (acc) begin
      mhead = 2'(req); mcur = 2'(req); mrem = HOLD; mpv = 1'b0;
    end else if (mpv) begin
      mhead = mpd; mcur = mpd; mrem = HOLD; mpv = 1'b0;
    end
    mpress = mrose & ~{4{g}};
    for (int b = 0; b < 4; b++) begin
      flip = 1'b1;
      for (int j = 1; j <= DC; j++) if (hist[j][b] == mdb[b]) flip = 1'b0;
      mrose[b] = flip && !mdb[b];
      if (flip) mdb[b] = ~mdb[b];
    end
    for (int j = DC; j >= 1; j--) hist[j] = hist[j-1];
    hist[0] = r;
  endfunction

  function automatic logic [6:0] m_exp();
    logic [3:0] o;
    o = (mrem > 0) ? (4'b0001 << mcur) : 4'b0000;
    return {(mrem > 0), mhead, o};
  endfunction

  // ---------------- stimulus plumbing ----------------
  task automatic tick();
    @(posedge clk);
    model_edge(btn, game_over);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive_tick(input logic [3:0] b, input logic g);
    btn = b;
    game_over = g;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b0; btn = '0; game_over = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0; btn = '0; game_over = 1'b0;
    model_reset();
    repeat (5) begin
      @(negedge clk);
      total++;
      if (obs !== 7'b0110000) begin bad++; $display("FAIL reset_hold got=%b want=%b", obs, 7'b0110000); end
    end
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_tick(4'b0000, 1'b0);
      total++;
      if (obs !== m_exp()) begin bad++; $display("FAIL reset_idle cyc=%0d got=%b want=%b", cyc, obs, m_exp()); end
    end
  endtask

  task automatic test_up_press();
    int k, first, n_up, n_other;
    do_reset();
    k = 0; first = -1; n_up = 0; n_other = 0;
    for (int i = 0; i < 26; i++) begin
      drive_tick((i < 20) ? 4'b0001 : 4'b0000, 1'b0);
      if (i == 0) k = cyc;
      total++;
      if (obs !== m_exp()) begin bad++; $display("FAIL up_press cyc=%0d got=%b want=%b", cyc, obs, m_exp()); end
      if (up) begin n_up++; if (first < 0) first = cyc; end
      if (down | left | right) n_other++;
    end
    total++;
    if (first - k != 7) begin bad++; $display("FAIL up_latency got=%0d want=7", first - k); end
    total++;
    if (n_up != 2) begin bad++; $display("FAIL up_width got=%0d want=2", n_up); end
    total++;
    if (heading !== 2'd0 || n_other != 0) begin
      bad++; $display("FAIL up_heading heading=%0d others=%0d want heading=0 others=0", heading, n_other);
    end
  endtask

  task automatic test_reversal();
    int pulses;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      drive_tick((i < 12) ? 4'b0100 : (i >= 20 && i < 32) ? 4'b1000 : 4'b0000, 1'b0);
      total++;
      if (obs !== m_exp()) begin bad++; $display("FAIL reversal cyc=%0d got=%b want=%b", cyc, obs, m_exp()); end
      if (up | down | left | right) pulses++;
    end
    total++;
    if (pulses != 0 || heading !== 2'd3) begin
      bad++; $display("FAIL reversal_result pulse_cycles=%0d heading=%0d want 0 and 3", pulses, heading);
    end
  endtask

  task automatic test_bounce();
    int n_bounce, n_down;
    logic pd;
    do_reset();
    n_bounce = 0; n_down = 0; pd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_tick((i < 12 && ((i / 2) % 2 == 0)) ? 4'b0010 : 4'b0000, 1'b0);
      total++;
      if (obs !== m_exp()) begin bad++; $display("FAIL bounce cyc=%0d got=%b want=%b", cyc, obs, m_exp()); end
      if (down) n_bounce++;
    end
    for (int i = 0; i < 16; i++) begin
      drive_tick((i < 10) ? 4'b0010 : 4'b0000, 1'b0);
      total++;
      if (obs !== m_exp()) begin bad++; $display("FAIL bounce_hold cyc=%0d got=%b want=%b", cyc, obs, m_exp()); end
      if (down && !pd) n_down++;
      pd = down;
    end
    total++;
    if (n_bounce != 0) begin bad++; $display("FAIL bounce_glitch got=%0d want=0", n_bounce); end
    total++;
    if (n_down != 1 || heading !== 2'd1) begin
      bad++; $display("FAIL bounce_pulse pulses=%0d heading=%0d want 1 and 1", n_down, heading);
    end
  endtask

  task automatic test_priority_pending();
    int n_up, n_left, first_up, first_left;
    logic pu, pl;
    do_reset();
    n_up = 0; n_left = 0; pu = 1'b0; pl = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_tick(4'b0101, 1'b0);
      total++;
      if (obs !== m_exp()) begin bad++; $display("FAIL priority cyc=%0d got=%b want=%b", cyc, obs, m_exp()); end
      if (up && !pu) n_up++;
      if (left && !pl) n_left++;
      pu = up; pl = left;
    end
    total++;
    if (n_up != 1 || n_left != 0) begin
      bad++; $display("FAIL priority_result up=%0d left=%0d want 1 and 0", n_up, n_left);
    end
    do_reset();
    first_up = -1; first_left = -1;
    for (int i = 0; i < 24; i++) begin
      drive_tick({1'b0, (i >= 1), 1'b0, 1'b1}, 1'b0);
      total++;
      if (obs !== m_exp()) begin bad++; $display("FAIL pending cyc=%0d got=%b want=%b", cyc, obs, m_exp()); end
      if (up && first_up < 0) first_up = cyc;
      if (left && first_left < 0) first_left = cyc;
    end
    total++;
    if (first_up < 0 || first_left - first_up != 3) begin
      bad++; $display("FAIL pending_gap got=%0d want=3", first_left - first_up);
    end
    total++;
    if (heading !== 2'd2) begin bad++; $display("FAIL pending_heading got=%0d want=2", heading); end
  endtask

  task automatic test_game_over();
    int n_quiet, n_left;
    logic seen, pl;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      drive_tick({1'b0, (i >= 1), 1'b0, 1'b1}, 1'b0);
      total++;
      if (obs !== m_exp()) begin bad++; $display("FAIL gover_setup cyc=%0d got=%b want=%b", cyc, obs, m_exp()); end
      if (up) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL gover_no_pulse got=0 want=1"); end
    drive_tick(4'b0101, 1'b1);
    total++;
    if ({busy, right, left, down, up} !== 5'b0) begin
      bad++; $display("FAIL gover_cut got=%b want=00000", {busy, right, left, down, up});
    end
    n_quiet = 0;
    for (int i = 0; i < 30; i++) begin
      drive_tick((i < 8) ? 4'b0101 : 4'b0100, (i < 12));
      total++;
      if (obs !== m_exp()) begin bad++; $display("FAIL gover_hold cyc=%0d got=%b want=%b", cyc, obs, m_exp()); end
      if (up | down | left | right) n_quiet++;
    end
    total++;
    if (n_quiet != 0) begin bad++; $display("FAIL gover_quiet pulse_cycles=%0d want=0", n_quiet); end
    n_left = 0; pl = 1'b0;
    for (int i = 0; i < 24; i++) begin
      drive_tick((i >= 8 && i < 20) ? 4'b0100 : 4'b0000, 1'b0);
      total++;
      if (obs !== m_exp()) begin bad++; $display("FAIL gover_repress cyc=%0d got=%b want=%b", cyc, obs, m_exp()); end
      if (left && !pl) n_left++;
      pl = left;
    end
    total++;
    if (n_left != 1 || heading !== 2'd2) begin
      bad++; $display("FAIL gover_result pulses=%0d heading=%0d want 1 and 2", n_left, heading);
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic seen;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      drive_tick(4'b0001, 1'b0);
      total++;
      if (obs !== m_exp()) begin bad++; $display("FAIL midrst_setup cyc=%0d got=%b want=%b", cyc, obs, m_exp()); end
      if (up) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL midrst_no_pulse got=0 want=1"); end
    #3 reset = 1'b0; btn = '0;
    #2;
    total++;
    if (obs !== 7'b0110000) begin bad++; $display("FAIL midrst_async got=%b want=%b", obs, 7'b0110000); end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_tick(4'b0000, 1'b0);
      total++;
      if (obs !== m_exp()) begin bad++; $display("FAIL midrst_after cyc=%0d got=%b want=%b", cyc, obs, m_exp()); end
    end
  endtask

  task automatic test_random();
    logic [3:0] b;
    logic       g;
    int         len;
    do_reset();
    for (int s = 0; s < 220; s++) begin
      b   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) b = '0;
      g   = ($urandom_range(0, 11) == 0);
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        drive_tick(b, g);
        total++;
        if (obs !== m_exp()) begin bad++; $display("FAIL random cyc=%0d got=%b want=%b", cyc, obs, m_exp()); end
      end
    end
  endtask

  initial begin
    reset = 1'b0; btn = '0; game_over = 1'b0;
    model_reset();
    test_reset();
    test_up_press();
    test_reversal();
    test_bounce();
    test_priority_pending();
    test_game_over();
    test_reset_mid_pulse();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
